// File: rtl/motor_emf_filter.sv
// Per-motor back-EMF conditioner: drops overflowed samples, forms a 2^AVG_SHIFT moving average
// and raises a sticky fault when the filtered magnitude stays above threshold long enough.
module motor_emf_filter #(
    parameter int unsigned AVG_SHIFT = 3,
    parameter int unsigned PERSIST_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 emf_ready,
    input  logic [16:0]          emf_in,
    input  logic                 emf_overflow,
    input  logic                 clear,
    input  logic [15:0]          emf_thresh,
    input  logic [PERSIST_W-1:0] persist_lim,
    output logic                 filt_ready,
    output logic                 filt_valid,
    output logic [16:0]          filt_out,
    output logic                 emf_fault,
    output logic [7:0]           ovf_count
);

    localparam int unsigned DEPTH  = 1 << AVG_SHIFT;
    localparam int unsigned SUM_W  = 17 + AVG_SHIFT;
    localparam int unsigned FILL_W = AVG_SHIFT + 1;

    typedef enum logic [0:0] {
        StFill,
        StRun
    } state_e;

    state_e state_q, state_d;

    // Stage 0: captured sample waiting for its overflow qualifier
    logic [16:0] s_data_q;
    logic        s_pend_q;

    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [AVG_SHIFT-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]       fill_cnt_q, fill_cnt_d;
    logic [PERSIST_W-1:0]    persist_q, persist_d;

    logic [16:0] filt_out_q, filt_out_d;
    logic        filt_ready_q, filt_ready_d;
    logic        filt_valid_q, filt_valid_d;
    logic        emf_fault_q, emf_fault_d;
    logic [7:0]  ovf_count_q, ovf_count_d;

    logic [16:0] win_mem [DEPTH];

    logic                    accept;
    logic                    drop;
    logic [16:0]             evict;
    logic signed [SUM_W-1:0] add_term;
    logic signed [SUM_W-1:0] sub_term;
    logic signed [SUM_W-1:0] new_sum;
    logic [16:0]             new_filt;
    logic [16:0]             filt_mag;
    logic                    over_thresh;
    logic [PERSIST_W-1:0]    lim_eff;

    assign accept = s_pend_q & ~emf_overflow & ~clear;
    assign drop   = s_pend_q & emf_overflow & ~clear;

    // Nothing is evicted until the window has been filled once
    assign evict    = (state_q == StRun) ? win_mem[wr_ptr_q] : 17'd0;
    assign add_term = {{AVG_SHIFT{s_data_q[16]}}, s_data_q};
    assign sub_term = {{AVG_SHIFT{evict[16]}}, evict};
    assign new_sum  = sum_q + add_term - sub_term;

    // Upper bits of the sum are the floor of the mean (arithmetic shift, truncated to 17 bits)
    assign new_filt = new_sum[SUM_W-1:AVG_SHIFT];

    // Magnitude is 17-bit unsigned so that -65536 maps to 65536
    assign filt_mag    = new_filt[16] ? (~new_filt + 17'd1) : new_filt;
    assign over_thresh = filt_mag > {1'b0, emf_thresh};
    assign lim_eff     = (persist_lim == '0) ? PERSIST_W'(1) : persist_lim;

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        wr_ptr_d     = wr_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        persist_d    = persist_q;
        filt_out_d   = filt_out_q;
        filt_ready_d = 1'b0;
        filt_valid_d = filt_valid_q;
        emf_fault_d  = emf_fault_q;
        ovf_count_d  = ovf_count_q;

        if (clear) begin
            state_d      = StFill;
            sum_d        = '0;
            wr_ptr_d     = '0;
            fill_cnt_d   = '0;
            persist_d    = '0;
            filt_out_d   = '0;
            filt_valid_d = 1'b0;
            emf_fault_d  = 1'b0;
            ovf_count_d  = '0;
        end else if (drop) begin
            if (ovf_count_q != 8'hFF) begin
                ovf_count_d = ovf_count_q + 8'd1;
            end
        end else if (accept) begin
            sum_d        = new_sum;
            wr_ptr_d     = wr_ptr_q + AVG_SHIFT'(1);
            filt_out_d   = new_filt;
            filt_ready_d = 1'b1;

            unique case (state_q)
                StFill: begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    if (fill_cnt_d == FILL_W'(DEPTH)) begin
                        state_d      = StRun;
                        filt_valid_d = 1'b1;
                    end
                end
                StRun: begin
                    if (over_thresh) begin
                        if (persist_q != '1) begin
                            persist_d = persist_q + PERSIST_W'(1);
                        end
                    end else begin
                        persist_d = '0;
                    end
                    if (persist_d >= lim_eff) begin
                        emf_fault_d = 1'b1;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_data_q <= '0;
            s_pend_q <= 1'b0;
        end else begin
            s_pend_q <= emf_ready & ~clear;
            if (emf_ready) begin
                s_data_q <= emf_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFill;
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            persist_q    <= '0;
            filt_out_q   <= '0;
            filt_ready_q <= 1'b0;
            filt_valid_q <= 1'b0;
            emf_fault_q  <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            persist_q    <= persist_d;
            filt_out_q   <= filt_out_d;
            filt_ready_q <= filt_ready_d;
            filt_valid_q <= filt_valid_d;
            emf_fault_q  <= emf_fault_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    // Window storage carries no reset; stale entries are never read while filling
    always_ff @(posedge clk) begin
        if (accept) begin
            win_mem[wr_ptr_q] <= s_data_q;
        end
    end

    assign filt_ready = filt_ready_q;
    assign filt_valid = filt_valid_q;
    assign filt_out   = filt_out_q;
    assign emf_fault  = emf_fault_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_motor_emf_filter.sv
// Bench for motor_emf_filter (AVG_SHIFT=2): directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_motor_emf_filter;

    localparam int S = 2;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        emf_ready;
    logic [16:0] emf_in;
    logic        emf_overflow;
    logic        clear;
    logic [15:0] emf_thresh;
    logic [7:0]  persist_lim;
    logic        filt_ready;
    logic        filt_valid;
    logic [16:0] filt_out;
    logic        emf_fault;
    logic [7:0]  ovf_count;

    motor_emf_filter #(
        .AVG_SHIFT(S),
        .PERSIST_W(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .emf_ready   (emf_ready),
        .emf_in      (emf_in),
        .emf_overflow(emf_overflow),
        .clear       (clear),
        .emf_thresh  (emf_thresh),
        .persist_lim (persist_lim),
        .filt_ready  (filt_ready),
        .filt_valid  (filt_valid),
        .filt_out    (filt_out),
        .emf_fault   (emf_fault),
        .ovf_count   (ovf_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int fout();
        return int'($signed(filt_out));
    endfunction

    task automatic send(int din, bit ovf);
        emf_ready = 1'b1;
        emf_in    = 17'(din);
        step();
        emf_ready    = 1'b0;
        emf_overflow = ovf;
        step();
        emf_overflow = 1'b0;
    endtask

    // Reference model: window of accepted samples, mean by floor division
    int m_win[$];
    bit m_pend;
    int m_data;
    int m_ovf;
    int m_persist;
    bit m_fault;
    bit m_valid;
    bit m_ready;
    int m_out;

    function automatic int fdiv(int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic void model_clear();
        m_win.delete();
        m_pend    = 1'b0;
        m_data    = 0;
        m_ovf     = 0;
        m_persist = 0;
        m_fault   = 1'b0;
        m_valid   = 1'b0;
        m_ready   = 1'b0;
        m_out     = 0;
    endfunction

    function automatic void model_edge(bit rdy, int din, bit ovf, bit clr, int thr, int lim);
        bit was_full;
        int sum;
        int mag;
        int lim_eff;
        if (clr) begin
            model_clear();
            return;
        end
        m_ready = 1'b0;
        if (m_pend) begin
            if (ovf) begin
                if (m_ovf < 255) m_ovf++;
            end else begin
                was_full = (m_win.size() == N);
                m_win.push_back(m_data);
                if (m_win.size() > N) void'(m_win.pop_front());
                sum = 0;
                foreach (m_win[k]) sum += m_win[k];
                m_out   = fdiv(sum);
                m_ready = 1'b1;
                m_valid = (m_win.size() == N);
                if (was_full) begin
                    mag = (m_out < 0) ? -m_out : m_out;
                    if (mag > thr) begin
                        if (m_persist < 255) m_persist++;
                    end else begin
                        m_persist = 0;
                    end
                    lim_eff = (lim == 0) ? 1 : lim;
                    if (m_persist >= lim_eff) m_fault = 1'b1;
                end
            end
        end
        m_pend = rdy;
        m_data = din;
    endfunction

    typedef struct {
        int din;
        bit ovf;
        bit clr;
        bit e_ready;
        int e_out;
        bit e_valid;
        bit e_fault;
        int e_ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit seen;
        logic [16:0] r17;
        bit r_rdy, r_ovf, r_clr;
        int r_din;

        reset        = 1'b1;
        emf_ready    = 1'b0;
        emf_in       = '0;
        emf_overflow = 1'b0;
        clear        = 1'b0;
        emf_thresh   = 16'd300;
        persist_lim  = 8'd3;

        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        check("reset_ready", int'(filt_ready), 0);
        check("reset_valid", int'(filt_valid), 0);
        check("reset_out", fout(), 0);
        check("reset_fault", int'(emf_fault), 0);
        check("reset_ovf", int'(ovf_count), 0);

        //                din    ovf clr rdy out  val flt ovf
        tbl.push_back('{100,   0, 0, 1, 25,   0, 0, 0});
        tbl.push_back('{200,   0, 0, 1, 75,   0, 0, 0});
        tbl.push_back('{300,   0, 0, 1, 150,  0, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 250,  1, 0, 0});
        tbl.push_back('{500,   0, 0, 1, 350,  1, 0, 0});
        tbl.push_back('{0,     0, 1, 0, 0,    0, 0, 0});
        tbl.push_back('{-5,    0, 0, 1, -2,   0, 0, 0});
        tbl.push_back('{-5,    0, 0, 1, -3,   0, 0, 0});
        tbl.push_back('{-5,    0, 0, 1, -4,   0, 0, 0});
        tbl.push_back('{-6,    0, 0, 1, -6,   1, 0, 0});
        tbl.push_back('{1000,  1, 0, 0, -6,   1, 0, 1});
        tbl.push_back('{0,     0, 1, 0, 0,    0, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 100,  0, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 200,  0, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 300,  0, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 400,  1, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 400,  1, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 400,  1, 0, 0});
        tbl.push_back('{-400,  0, 0, 1, 200,  1, 0, 0});
        tbl.push_back('{1200,  0, 0, 1, 400,  1, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 400,  1, 0, 0});
        tbl.push_back('{400,   0, 0, 1, 400,  1, 1, 0});
        tbl.push_back('{-2000, 0, 0, 1, 0,    1, 1, 0});
        tbl.push_back('{1000,  0, 0, 1, -50,  1, 1, 0});

        foreach (tbl[i]) begin
            if (tbl[i].clr) begin
                clear = 1'b1;
                step();
                clear = 1'b0;
            end else begin
                emf_ready = 1'b1;
                emf_in    = 17'(tbl[i].din);
                step();
                emf_ready = 1'b0;
                check($sformatf("vec%0d_early_ready", i), int'(filt_ready), 0);
                emf_overflow = tbl[i].ovf;
                step();
                emf_overflow = 1'b0;
            end
            check($sformatf("vec%0d_ready", i), int'(filt_ready), int'(tbl[i].e_ready));
            check($sformatf("vec%0d_out", i), fout(), tbl[i].e_out);
            check($sformatf("vec%0d_valid", i), int'(filt_valid), int'(tbl[i].e_valid));
            check($sformatf("vec%0d_fault", i), int'(emf_fault), int'(tbl[i].e_fault));
            check($sformatf("vec%0d_ovf", i), int'(ovf_count), tbl[i].e_ovf);
        end

        // clear on the same edge as a stage-1 accept while faulted
        emf_ready = 1'b1;
        emf_in    = 17'd77;
        step();
        emf_ready = 1'b0;
        clear     = 1'b1;
        step();
        clear = 1'b0;
        check("clr_ready", int'(filt_ready), 0);
        check("clr_out", fout(), 0);
        check("clr_valid", int'(filt_valid), 0);
        check("clr_fault", int'(emf_fault), 0);
        step();
        check("clr_no_late_ready", int'(filt_ready), 0);

        // clear on the stage-0 capture edge also drops the sample
        emf_ready = 1'b1;
        emf_in    = 17'd55;
        clear     = 1'b1;
        step();
        clear     = 1'b0;
        emf_ready = 1'b0;
        step();
        check("clr_s0_ready", int'(filt_ready), 0);

        send(8, 0);
        send(8, 0);
        send(8, 0);
        check("refill3_valid", int'(filt_valid), 0);
        send(8, 0);
        check("refill4_valid", int'(filt_valid), 1);
        check("refill4_out", fout(), 8);

        // overflow flood, back-to-back
        seen         = 1'b0;
        emf_ready    = 1'b1;
        emf_overflow = 1'b1;
        emf_in       = 17'd1000;
        for (int i = 0; i < 302; i++) begin
            step();
            if (filt_ready) seen = 1'b1;
        end
        emf_ready = 1'b0;
        step();
        if (filt_ready) seen = 1'b1;
        emf_overflow = 1'b0;
        check("flood_ovf_sat", int'(ovf_count), 255);
        check("flood_no_ready", int'(seen), 0);
        check("flood_out_kept", fout(), 8);
        check("flood_valid_kept", int'(filt_valid), 1);

        // asynchronous reset between edges
        send(40, 0);
        check("pre_rst_out", fout(), 16);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_out", fout(), 0);
        check("arst_valid", int'(filt_valid), 0);
        check("arst_ovf", int'(ovf_count), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        send(12, 0);
        send(12, 0);
        send(12, 0);
        check("rst_refill3_valid", int'(filt_valid), 0);
        check("rst_refill3_out", fout(), 9);
        send(-4, 0);
        check("rst_refill4_valid", int'(filt_valid), 1);
        check("rst_refill4_out", fout(), 8);

        // randomized run against the reference model
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        emf_thresh  = 16'd800;
        persist_lim = 8'd2;
        for (int c = 0; c < 3000; c++) begin
            r_rdy = ($urandom_range(0, 1) == 1);
            r_ovf = ($urandom_range(0, 3) == 0);
            r_clr = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) begin
                r17   = 17'($urandom());
                r_din = int'($signed(r17));
            end else begin
                r_din = int'($urandom_range(0, 4000)) - 2000;
            end
            if ($urandom_range(0, 31) == 0) emf_thresh = 16'($urandom_range(100, 1500));
            if ($urandom_range(0, 31) == 0) persist_lim = 8'($urandom_range(0, 4));
            emf_ready    = r_rdy;
            emf_in       = 17'(r_din);
            emf_overflow = r_ovf;
            clear        = r_clr;
            step();
            model_edge(r_rdy, r_din, r_ovf, r_clr, int'(emf_thresh), int'(persist_lim));
            checks++;
            if (filt_ready != m_ready || filt_valid != m_valid || fout() != m_out ||
                emf_fault != m_fault || int'(ovf_count) != m_ovf) begin
                errors++;
                $display("FAIL rand_cycle%0d: got rdy=%0d val=%0d out=%0d flt=%0d ovf=%0d expected rdy=%0d val=%0d out=%0d flt=%0d ovf=%0d",
                         c, filt_ready, filt_valid, fout(), emf_fault, ovf_count,
                         m_ready, m_valid, m_out, m_fault, m_ovf);
            end
        end
        emf_ready    = 1'b0;
        emf_overflow = 1'b0;
        clear        = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
